// File: rtl/top_ram_banked.sv
// Simple dual-port RAM with lane enables, a read valid pipeline and a zero-clear sequencer.
// Latency: a read accepted in cycle t presents q/rdvalid in cycle t+2; writes land on the accepting edge.
// Backpressure: none. Requests are dropped while busy=1, and one read plus one write are accepted per cycle otherwise.
//
// Ports:
//   clock, reset        single rising-edge clock and asynchronous active-high reset
//   data, byteena       write word and per-lane write enables (lane i = data[(i+1)*LW-1:i*LW])
//   wraddress, wren     write address and request
//   rdaddress, rden     read address and request
//   q, rdvalid          registered read data and its valid flag
//   busy                clear sequence in progress
//   collision           one-cycle pulse: same-address read and write accepted in the previous cycle
//
// Build option: define TOP_RAM_FWD_EN to forward same-cycle write data into a colliding read.
// Without it, a colliding read returns unspecified data. rdvalid and collision still flag that read.
module top_ram_banked #(
  parameter int TOPWIDTH     = 32,
  parameter int TOPSIZE      = 1024,
  parameter int TOPSIZEWIDTH = 10,
  parameter int LANES        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [TOPWIDTH-1:0]     data,
  input  logic [LANES-1:0]        byteena,
  input  logic [TOPSIZEWIDTH-1:0] wraddress,
  input  logic                    wren,
  input  logic [TOPSIZEWIDTH-1:0] rdaddress,
  input  logic                    rden,
  output logic [TOPWIDTH-1:0]     q,
  output logic                    rdvalid,
  output logic                    busy,
  output logic                    collision
);

  localparam int LW = TOPWIDTH / LANES;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]              state;
  logic [TOPSIZEWIDTH-1:0] clr_cnt;
  logic [TOPWIDTH-1:0]     mem [TOPSIZE];
  logic [TOPWIDTH-1:0]     rd_raw;
  logic [TOPWIDTH-1:0]     q_nxt;
  logic                    rd_vld;
  logic                    wr_acc;
  logic                    rd_acc;

  assign busy   = (state == ST_CLEAR);
  assign wr_acc = wren & ~busy;
  assign rd_acc = rden & ~busy;

  // Clear sequencer: one word per cycle. The final word is written on the same edge that enters READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == TOPSIZEWIDTH'(TOPSIZE - 1))
        state <= ST_READY;
    end
  end

  // Memory array with no reset, shaped for block RAM inference. The clear sequencer owns the
  // write port while busy. The read samples the array on the edge that accepts the request,
  // so a write accepted on that same edge is not visible in rd_raw.
  always_ff @(posedge clock) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteena[i])
          mem[wraddress][i*LW +: LW] <= data[i*LW +: LW];
      end
    end
    rd_raw <= mem[rdaddress];
  end

`ifdef TOP_RAM_FWD_EN
  logic [TOPWIDTH-1:0] fwd_dat;
  logic [LANES-1:0]    fwd_be;

  // Hold the previous cycle's write. The collision flag selects it for the read that sampled stale data.
  always_ff @(posedge clock) begin
    fwd_dat <= data;
    fwd_be  <= byteena;
  end

  always_comb begin
    q_nxt = rd_raw;
    if (collision) begin
      for (int i = 0; i < LANES; i++) begin
        if (fwd_be[i])
          q_nxt[i*LW +: LW] = fwd_dat[i*LW +: LW];
      end
    end
  end
`else
  assign q_nxt = rd_raw;
`endif

  // Output stage. q only moves when a read completes, so it holds its value between reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_vld    <= 1'b0;
      rdvalid   <= 1'b0;
      collision <= 1'b0;
      q         <= '0;
    end else begin
      rd_vld    <= rd_acc;
      rdvalid   <= rd_vld;
      collision <= rd_acc & wr_acc & (rdaddress == wraddress);
      if (rd_vld)
        q <= q_nxt;
    end
  end

endmodule

// File: tb/tb_top_ram_banked.sv
// Self-checking bench for top_ram_banked: a reference memory plus scoreboard queues for reads and collisions.
module tb_top_ram_banked;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data = '0;
  logic [3:0]  byteena = '0;
  logic [9:0]  wraddress = '0;
  logic        wren = 1'b0;
  logic [9:0]  rdaddress = '0;
  logic        rden = 1'b0;
  logic [31:0] q;
  logic        rdvalid;
  logic        busy;
  logic        collision;

  top_ram_banked #(.TOPWIDTH(32), .TOPSIZE(1024), .TOPSIZEWIDTH(10), .LANES(4)) dut (
    .clock(clock), .reset(reset), .data(data), .byteena(byteena), .wraddress(wraddress),
    .wren(wren), .rdaddress(rdaddress), .rden(rden), .q(q), .rdvalid(rdvalid),
    .busy(busy), .collision(collision)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic [31:0] msk;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          coll_q[$];
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  int          rst_rel = 0;
  bit          in_reset = 1'b1;
  bit          mon_en = 1'b0;
  bit          q_known = 1'b1;
  logic [31:0] q_last = '0;
  int          busy_cnt = 0;
  int          n_chk = 0;
  int          n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Drive one cycle of stimulus and record what the DUT must return for it.
  task automatic drv(input bit wr, input int wa, input logic [31:0] wd, input logic [3:0] be,
                     input bit rd, input int ra);
    rd_exp_t e;
    bit bsy, aw, ar;
    @(posedge clock);
    #1;
    wren = wr; wraddress = 10'(wa); data = wd; byteena = be;
    rden = rd; rdaddress = 10'(ra);
    bsy = in_reset || ((cyc - rst_rel) < 1024);
    aw = wr && !bsy;
    ar = rd && !bsy;
    if (ar) begin
      e.due = cyc + 2;
      e.msk = '1;
      e.dat = ref_mem[ra];
      if (aw && (wa == ra)) begin
`ifdef TOP_RAM_FWD_EN
        e.dat = merge(ref_mem[ra], wd, be);
`else
        e.msk = '0;
`endif
        coll_q.push_back(cyc + 1);
      end
      rd_q.push_back(e);
    end
    if (aw) ref_mem[wa] = merge(ref_mem[wa], wd, be);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 32'h0, 4'h0, 0, 0);
  endtask

  task automatic mon_step();
    rd_exp_t e;
    bit eb, erv, ec;
    eb = (cyc - rst_rel) < 1024;
    chk("busy", {31'b0, busy}, {31'b0, eb});
    if (busy) busy_cnt++;
    while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
      e = rd_q.pop_front();
      chk("rd_late", cyc, e.due);
    end
    erv = (rd_q.size() > 0) && (rd_q[0].due == cyc);
    chk("rdvalid", {31'b0, rdvalid}, {31'b0, erv});
    if (erv) begin
      e = rd_q.pop_front();
      if (e.msk != '0) chk("q", q, e.dat);
      q_known = (e.msk == '1);
      q_last = e.dat;
    end else if (q_known) begin
      chk("q_hold", q, q_last);
    end
    ec = (coll_q.size() > 0) && (coll_q[0] == cyc);
    if (ec) void'(coll_q.pop_front());
    chk("collision", {31'b0, collision}, {31'b0, ec});
  endtask

  // Assert reset at the current time, check the async values, hold it, then release just after an edge.
  task automatic do_reset(input int hold);
    mon_en = 1'b0;
    in_reset = 1'b1;
    reset = 1'b1;
    rden = 1'b0;
    wren = 1'b0;
    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_rdvalid", {31'b0, rdvalid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_collision", {31'b0, collision}, 32'h0);
    rd_q.delete();
    coll_q.delete();
    q_known = 1'b1;
    q_last = '0;
    busy_cnt = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    repeat (hold) @(posedge clock);
    #1;
    reset = 1'b0;
    in_reset = 1'b0;
    rst_rel = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      forever begin
        @(negedge clock);
        if (mon_en) mon_step();
      end
    join_none

    #2;
    do_reset(3);

    // Clear phase: busy for exactly 1024 cycles, followed by a full sweep that reads back zeros.
    idle(1030);
    chk("busy_len", busy_cnt, 1024);
    for (int a = 0; a < 1024; a++) drv(0, 0, 32'h0, 4'h0, 1, a);
    idle(3);

    // Full write followed by a read, then a partial-lane overwrite.
    drv(1, 5, 32'hDEADBEEF, 4'hF, 0, 0);
    drv(0, 0, 32'h0, 4'h0, 1, 5);
    idle(3);
    drv(1, 5, 32'h11223344, 4'b0101, 0, 0);
    drv(0, 0, 32'h0, 4'h0, 1, 5);
    idle(3);
    chk("merge_model", ref_mem[5], 32'hDE22BE44);

    // Same-cycle collision on address 9, then a normal read of the result.
    drv(1, 9, 32'hA5A5A5A5, 4'b0011, 1, 9);
    idle(3);
    drv(0, 0, 32'h0, 4'h0, 1, 9);
    idle(3);

    // A write with byteena=0 changes nothing.
    drv(1, 6, 32'hFFFFFFFF, 4'h0, 0, 0);
    drv(0, 0, 32'h0, 4'h0, 1, 6);
    idle(3);

    // Preload 0..7, then read back-to-back. Address 3 is rewritten one cycle after its read.
    for (int a = 0; a < 8; a++) drv(1, a, 32'(a), 4'hF, 0, 0);
    for (int a = 0; a < 8; a++) begin
      if (a == 4) drv(1, 3, 32'h33333333, 4'hF, 1, a);
      else        drv(0, 0, 32'h0, 4'h0, 1, a);
    end
    drv(0, 0, 32'h0, 4'h0, 1, 3);
    idle(3);

    // Random traffic on a small address window, which produces frequent collisions.
    for (int i = 0; i < 300; i++)
      drv(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    idle(3);

    // Reset while reads are in flight: rdvalid must drop without waiting for an edge.
    drv(0, 0, 32'h0, 4'h0, 1, 1);
    drv(0, 0, 32'h0, 4'h0, 1, 2);
    drv(0, 0, 32'h0, 4'h0, 1, 3);
    drv(0, 0, 32'h0, 4'h0, 0, 0);
    chk("pre_rst_rdvalid", {31'b0, rdvalid}, 32'h1);
    do_reset(2);

    // Reset again when the clear count reaches 500. Traffic during the restarted clear is ignored.
    idle(500);
    do_reset(2);
    for (int i = 0; i < 1024; i++) drv(1, 3, 32'hFFFFFFFF, 4'hF, 1, 3);
    idle(4);
    chk("busy_len2", busy_cnt, 1024);
    for (int a = 0; a < 8; a++) drv(0, 0, 32'h0, 4'h0, 1, a);
    idle(4);

    chk("rd_q_drain", rd_q.size(), 0);
    chk("coll_q_drain", coll_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
